fetch_prefetch_queue: RTL and testbench
=======================================

// Module: fetch_prefetch_queue
// PURPOSE
//  Instruction-fetch front end sitting directly upstream of the IF/ID pipeline register.
//  Owns the fetch PC, issues sequential reads to the synchronous instruction memory and
//  buffers fetched words in a small FIFO. Delivers {instr, PC+4} to IF/ID under a
//  valid/ready handshake, so hazard stalls do not lose fetches.
//  Flushes all buffered and in-flight fetches on a branch redirect (PCSrc path from EX/MEM).
// PARAMETERS
//  DEPTH     4      queue entries; power of two, >=2
//  RESET_PC  32'h0  fetch PC loaded on reset
//  CNT_W     $clog2(DEPTH+1)  occupancy counter width (derived, do not override)
// PORTS
//  clk            in   1      single clock; all state on posedge
//  reset_n        in   1      asynchronous, active-low reset
//  redirect_valid in   1      branch taken (PCSrc); flush and refetch from redirect_pc
//  redirect_pc    in   32     branch target from EX/MEM
//  imem_req       out  1      read request to instruction memory this cycle
//  imem_addr      out  32     byte address of request (= fetch PC)
//  imem_rdata     in   32     instruction word, valid exactly 1 cycle after imem_req
//  out_valid      out  1      queue head holds a valid fetch
//  out_ready      in   1      IF/ID accepts head this cycle (low = stall)
//  out_word       out  64     {instr[63:32], PC+4[31:0]}, IF/ID layout
//  occupancy      out  CNT_W  entries currently held
// BEHAVIOUR
//  - Reset (async assert): fetch PC=RESET_PC, queue empty, inflight=0, out_valid=0,
//    occupancy=0, imem_req=0, out_word=0. First request the cycle after reset_n rises.
//  - Credit: imem_req = !redirect_valid && (occupancy + inflight < DEPTH), where
//    inflight is the 1-bit flag "request issued last cycle". Queue never overflows.
//  - On issue: imem_addr=PC, PC<=PC+4 (32-bit, wraps 32'hFFFF_FFFC -> 0, no flag).
//  - Response: cycle after issue, if not squashed, push {imem_rdata, addr+4} to tail.
//  - Pop: out_valid && out_ready removes head; out_word is the registered head entry.
//  - Push and pop same cycle: occupancy unchanged; allowed when full (pop frees slot)
//    and when empty (pushed entry appears next cycle; no combinational bypass).
//  - Latency: redirect/reset -> first out_valid = 2 cycles; steady state 1 word/cycle.
//  - Redirect (has priority over everything): same cycle out_valid forced 0, no pop,
//    no issue; next edge: queue emptied, occupancy=0, PC<=redirect_pc, any response
//    arriving next cycle is squashed (not pushed). Fetch resumes the cycle after.
//  - Back-to-back redirects: last one wins; each re-squashes.
//  - Reset mid-operation: all entries and in-flight response discarded immediately.
//  - Pointers DEPTH-modulo; full = occupancy==DEPTH, empty = occupancy==0.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds ports perf_stall_cnt[31:0] (cycles with out_valid &&
//    !out_ready) and perf_flush_cnt[31:0] (cycles with redirect_valid); both reset to 0,
//    saturate at 32'hFFFF_FFFF.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Reset RESET_PC=0, out_ready=1, mem holds word k at 4k -> out_word=
//    {mem[0],32'h4},{mem[1],32'h8},... one per cycle from cycle 2 after reset release.
//  2 out_ready=0 for 10 cycles -> occupancy reaches DEPTH=4, imem_req=0 while full,
//    no word lost or duplicated after out_ready=1 (PC+4 sequence contiguous).
//  3 redirect_valid 1 cycle, redirect_pc=32'h40, with 3 queued + 1 in flight ->
//    out_valid=0 that cycle, occupancy=0 next, next delivered word {mem[16],32'h44}.
//  4 Redirect in two consecutive cycles (32'h40 then 32'h80) -> first delivered PC+4=32'h84.
//  5 Start at RESET_PC=32'hFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000;
//    PC+4 fields FFFF_FFFC, 0000_0000, 0000_0004.
//  6 Assert reset_n=0 asynchronously mid-burst with queue full -> out_valid, occupancy,
//    imem_req drop to 0 before next edge; restart fetch from RESET_PC.

Source files
------------

// File: rtl/fetch_prefetch_queue_if.sv
// fetch_prefetch_queue_if: redirect, instruction-memory and IF/ID handshake bundle for the fetch queue.
interface fetch_prefetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_rdata;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_word;
  logic [CNT_W-1:0] occupancy;
  modport master (
    input  redirect_valid, redirect_pc, imem_rdata, out_ready,
    output imem_req, imem_addr, out_valid, out_word, occupancy
  );
  modport slave (
    output redirect_valid, redirect_pc, imem_rdata, out_ready,
    input  imem_req, imem_addr, out_valid, out_word, occupancy
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: fetch PC, sequential imem reads and a DEPTH-entry queue feeding IF/ID.
// Define FETCH_PERF_EN to add saturating stall/flush performance counters.
module fetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic clk,
  input  logic reset_n,
  fetch_prefetch_queue_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AW    = $clog2(DEPTH);
  logic [31:0]      pc_q;
  logic [63:0]      mem_q [DEPTH];
  logic [AW-1:0]    rd_q, wr_q;
  logic [CNT_W-1:0] occ_q;
  logic             infl_q, run_q;
  logic             issue, push, pop;
  // Credit counts the in-flight response so a full queue never receives an unplanned push.
  assign issue = run_q && !bus.redirect_valid && ((occ_q + CNT_W'(infl_q)) < CNT_W'(DEPTH));
  assign push  = infl_q && !bus.redirect_valid;
  assign pop   = bus.out_valid && bus.out_ready;
  assign bus.out_valid = !bus.redirect_valid && (occ_q != '0);
  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc_q;
  assign bus.out_word  = mem_q[rd_q];
  assign bus.occupancy = occ_q;
  // pc_q already holds addr+4 in the response cycle, giving the IF/ID PC+4 field for free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q   <= RESET_PC;
      rd_q   <= '0;
      wr_q   <= '0;
      occ_q  <= '0;
      infl_q <= 1'b0;
      run_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      run_q  <= 1'b1;
      infl_q <= issue;
      if (bus.redirect_valid) begin
        pc_q  <= bus.redirect_pc;
        rd_q  <= '0;
        wr_q  <= '0;
        occ_q <= '0;
      end else begin
        if (issue) pc_q <= pc_q + 32'd4;
        if (push) begin
          mem_q[wr_q] <= {bus.imem_rdata, pc_q};
          wr_q        <= wr_q + AW'(1);
        end
        if (pop) rd_q <= rd_q + AW'(1);
        occ_q <= occ_q + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (bus.out_valid && !bus.out_ready && !(&perf_stall_cnt)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (bus.redirect_valid && !(&perf_flush_cnt)) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb_fetch_prefetch_queue: scoreboard bench; expected fetch stream generated from redirect/reset targets.
module tb_fetch_prefetch_queue;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  fetch_prefetch_queue_if #(.DEPTH(DEPTH)) bus ();
  fetch_prefetch_queue_if #(.DEPTH(DEPTH)) bus2 ();
`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt, flush_cnt, stall_cnt2, flush_cnt2;
`endif
  fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
`ifdef FETCH_PERF_EN
    , .perf_stall_cnt(stall_cnt), .perf_flush_cnt(flush_cnt)
`endif
  );
  fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .bus(bus2)
`ifdef FETCH_PERF_EN
    , .perf_stall_cnt(stall_cnt2), .perf_flush_cnt(flush_cnt2)
`endif
  );
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction
  always @(posedge clk) begin
    bus.imem_rdata  <= mem(bus.imem_addr);
    bus2.imem_rdata <= mem(bus2.imem_addr);
  end
  int checks = 0;
  int errors = 0;
  int pops = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  // Reference stream: after a reset or redirect to P the delivered words are P, P+4, P+8 ...
  logic [63:0] sb [$];
  logic [31:0] gen_pc;
  task automatic refill();
    while (sb.size() < 8) begin
      sb.push_back({mem(gen_pc), gen_pc + 32'd4});
      gen_pc = gen_pc + 32'd4;
    end
  endtask
  task automatic restart(input logic [31:0] pc);
    sb.delete();
    gen_pc = pc;
    refill();
  endtask
  always @(posedge clk) begin
    #2;
    refill();
  end
  logic prev_redir = 1'b0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.redirect_valid) begin
        chk("redir_out_valid", bus.out_valid, 0);
        chk("redir_imem_req", bus.imem_req, 0);
      end
      if (prev_redir) chk("flush_occupancy", bus.occupancy, 0);
      if (bus.occupancy == DEPTH) chk("full_imem_req", bus.imem_req, 0);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty actual=%h required=none", bus.out_word);
        end else begin
          chk("out_word", bus.out_word, sb.pop_front());
          pops++;
        end
      end
      prev_redir = bus.redirect_valid;
    end else prev_redir = 1'b0;
  end
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic redirect(input logic [31:0] t);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = t;
    restart(t);
    step(1);
    bus.redirect_valid = 1'b0;
  endtask
  task automatic wait_occ(input int target, input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1);
      found = (bus.occupancy == target);
    end
    chk(name, found, 1);
  endtask
  initial begin
    logic [31:0] exp_a [3];
    logic [31:0] exp_p [3];
    int na, nw;
    exp_a = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    exp_p = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    na = 0;
    nw = 0;
    bus2.out_ready = 1'b1;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc = '0;
    @(posedge reset_n);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus2.imem_req && na < 3) begin
        chk("wrap_addr", bus2.imem_addr, exp_a[na]);
        na++;
      end
      if (bus2.out_valid && nw < 3) begin
        chk("wrap_word", bus2.out_word, {mem(exp_a[nw]), exp_p[nw]});
        nw++;
      end
    end
    chk("wrap_count", na + nw, 6);
  end
  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b1;
    restart(32'h0);
    step(3);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_occupancy", bus.occupancy, 0);
    chk("reset_imem_req", bus.imem_req, 0);
    chk("reset_out_word", bus.out_word, 0);
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("lat_c0_valid", bus.out_valid, 0);
    chk("lat_c0_req", bus.imem_req, 1);
    chk("lat_c0_addr", bus.imem_addr, 0);
    @(negedge clk);
    chk("lat_c1_valid", bus.out_valid, 0);
    @(negedge clk);
    chk("lat_c2_valid", bus.out_valid, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("stream_valid", bus.out_valid, 1);
    end
    step(1);
    bus.out_ready = 1'b0;
    step(10);
    chk("stall_occupancy", bus.occupancy, DEPTH);
    chk("stall_imem_req", bus.imem_req, 0);
    bus.out_ready = 1'b1;
    step(6);
    bus.out_ready = 1'b0;
    redirect(32'h0);
    wait_occ(3, "reach_occ3");
    chk("occ3_inflight_req", bus.imem_req, 0);
    redirect(32'h40);
    bus.out_ready = 1'b1;
    step(8);
    bus.out_ready = 1'b0;
    redirect(32'h40);
    redirect(32'h80);
    bus.out_ready = 1'b1;
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
        @(negedge clk);
        seen = bus.out_valid;
      end
      chk("b2b_first_valid", seen, 1);
      chk("b2b_first_pc4", bus.out_word[31:0], 32'h84);
    end
    step(4);
    bus.out_ready = 1'b0;
    wait_occ(DEPTH, "reach_full");
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_out_valid", bus.out_valid, 0);
    chk("async_occupancy", bus.occupancy, 0);
    chk("async_imem_req", bus.imem_req, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    restart(32'h0);
    step(3);
    #1;
    chk("restart_word", bus.out_word, {mem(32'h0), 32'h4});
    for (int c = 0; c < 1500; c++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0)
        redirect(($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + {$urandom_range(0, 3), 2'b00}
                                             : {$urandom_range(0, 255), 2'b00});
      else step(1);
    end
    bus.out_ready = 1'b1;
    step(12);
    chk("progress", pops > 500, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
